// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes engine: substitutes LANES bytes per clock over a 128-bit state.
// Optional macro SUBBYTES_INV_EN adds per-lane inverse S-boxes selected by the latched in_inv.
module sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned BEATS = 16 / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (bits 1..7 of the exponent); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

`ifdef SUBBYTES_INV_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [15:0][7:0]       buf_q, buf_d;
  logic [127:0]           out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, busy_q;
  logic [LANES-1:0][7:0]  lane_out;
  logic [LANES-1:0][3:0]  lane_idx;

`ifdef SUBBYTES_INV_EN
  logic inv_q, inv_d;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  // Lane j substitutes byte cnt*LANES+j of the work buffer.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] lane_in;
    assign lane_idx[j] = 4'(LANES * 32'(cnt_q) + 32'(j));
    assign lane_in     = buf_q[lane_idx[j]];
`ifdef SUBBYTES_INV_EN
    assign lane_out[j] = inv_q ? sbox_inv(lane_in) : sbox_fwd(lane_in);
`else
    assign lane_out[j] = sbox_fwd(lane_in);
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifdef SUBBYTES_INV_EN
    inv_d       = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_state;
          cnt_d   = '0;
`ifdef SUBBYTES_INV_EN
          inv_d   = in_inv;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < int'(LANES); j++) begin
          buf_d[lane_idx[j]] = lane_out[j];
        end
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          out_d       = buf_d;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef SUBBYTES_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
`ifdef SUBBYTES_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_q;
  assign busy      = busy_q;

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
Sequential, parametrised AES SubBytes engine. Accepts one 128-bit state over a valid/ready handshake. Substitutes LANES bytes per clock through LANES S-box instances, then presents the full 128-bit result over a valid/ready handshake. It sits between AddRoundKey and ShiftRows in the round datapath and trades S-box area for latency.

Parameters:
LANES, 4, number of S-box instances (bytes substituted per cycle); legal values 1, 2, 4, 8, 16.
BEATS, 16/LANES, derived local parameter, not overridable: cycles per state.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_state valid
in_ready  output  1  engine can accept a state
in_state  input  128  state to substitute; byte i = in_state[8i+7:8i]
in_inv  input  1  1 = InvSubBytes; used only with SUBBYTES_INV_EN
out_valid  output  1  out_state holds a finished result
out_ready  input  1  downstream accepts out_state
out_state  output  128  substituted state, same byte ordering as in_state
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, beat counter=0, work buffer=0, out_state=128'h0, out_valid=0, busy=0, in_ready=1, latched mode=forward.
- FSM has three states: IDLE, RUN and DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_state into the work buffer, capture in_inv, set counter=0 and go to RUN.
- RUN: in_ready=0. On beat k (0..BEATS-1), replace bytes k*LANES .. k*LANES+LANES-1 with their S-box outputs. Lane j handles byte k*LANES+j. Counter increments. After beat BEATS-1, write the buffer to out_state, set out_valid=1 and go to DONE.
- Latency: the accept edge is edge 0. out_valid rises after edge BEATS (LANES=16: 1 cycle; LANES=1: 16 cycles).
- DONE: out_valid=1, and out_state stays stable until the handshake. On out_valid&out_ready, clear out_valid and go to IDLE. out_state keeps its last value (not cleared).
- in_ready is high only in IDLE, so there is no overlap. Minimum spacing between accepted states is BEATS+2 cycles with out_ready held at 1.
- Changes on in_state/in_inv after the accept edge have no effect.
- out_ready asserted outside DONE is ignored.
- rst_n low in RUN or DONE aborts the operation. The partial result is discarded and no out_valid is produced.
- The S-box is purely combinational. There is no registered S-box stage.
- Illegal LANES value: elaboration error via generate-time check.

Optional Feature:
SUBBYTES_INV_EN
- Defined: each lane also instantiates an inverse S-box. in_inv is latched at accept, and the latched value selects forward or inverse for all beats of that state.
- Undefined: no inverse S-box is instantiated. in_inv is ignored and the forward S-box is always used.

Test Plan:
1. LANES=4, in_state=128'h0, out_ready=1:
   - out_valid rises 4 cycles after accept.
   - out_state=128'h63636363636363636363636363636363.
2. LANES=4, FIPS-197 vector, in_state=128'h00112233445566778899aabbccddeeff:
   - out_state=128'h638293c31bfc33f5c4eeacea4bc12816.
   - Repeat with LANES=1 (16-cycle latency) and LANES=16 (1-cycle latency); results must be identical.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
   - out_valid and out_state stay stable.
   - in_ready=0 throughout.
   - Release out_ready: one handshake, then in_ready=1 the next cycle.
4. Reset mid-operation: pulse rst_n low at beat 2 of a LANES=4 run.
   - All outputs reset immediately (async).
   - No out_valid follows.
   - A new state accepted afterwards completes correctly.
5. With SUBBYTES_INV_EN, in_inv=1:
   - in_state=128'h638293c31bfc33f5c4eeacea4bc12816 gives out_state=128'h00112233445566778899aabbccddeeff.
   - Without the macro, the same stimulus gives the forward substitution of that input.
6. Input stability: change in_state to 128'hff..ff one cycle after accept of 128'h0.
   - Output still equals 128'h6363...63.
